// File: rtl/ov5640_pkg.sv
// Shared timing defaults, FSM state encoding and pixel packing for the OV5640 DVP transmitter.
package ov5640_pkg;

  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_H_BLANK     = 144;
  localparam int DEF_VSYNC_LINES = 4;
  localparam int DEF_V_BACK      = 16;
  localparam int DEF_V_FRONT     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } dvp_state_t;

  // Returns {byte0, byte1}: byte0 = {R[7:3], G[7:5]}, byte1 = {G[4:2], B[7:3]}.
  function automatic logic [15:0] rgb888_to_565_bytes(input logic [23:0] rgb);
    return {rgb[23:19], rgb[15:13], rgb[12:10], rgb[7:3]};
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/dvp_timing_gen.sv
// Line/frame counters and phase FSM; strobes describe the cycle the output registers load next.
module dvp_timing_gen
  import ov5640_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int H_BLANK     = DEF_H_BLANK,
  parameter int VSYNC_LINES = DEF_VSYNC_LINES,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int V_FRONT     = DEF_V_FRONT
) (
  input  logic i_pclk,
  input  logic i_reset,
  input  logic i_enable,
  output logic o_vsync_nxt,
  output logic o_href_nxt,
  output logic o_byte0_nxt,
  output logic o_byte1_nxt,
  output logic o_first_pix_nxt,
  output logic o_last_pix_nxt,
  output logic o_frame_done_nxt,
  output logic o_vback
);

  localparam int LP   = 2 * H_ACTIVE + H_BLANK;
  localparam int HW   = (LP > 1) ? $clog2(LP) : 1;
  localparam int VMAX = max4(VSYNC_LINES, V_BACK, V_ACTIVE, V_FRONT);
  localparam int VW   = (VMAX > 1) ? $clog2(VMAX) : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(LP - 1);
  localparam logic [HW-1:0] HREF_END = HW'(2 * H_ACTIVE);
  localparam logic [HW-1:0] LAST_B0  = HW'(2 * H_ACTIVE - 2);
  localparam logic [VW-1:0] VS_LAST  = VW'(VSYNC_LINES - 1);
  localparam logic [VW-1:0] VB_LAST  = VW'(V_BACK - 1);
  localparam logic [VW-1:0] VA_LAST  = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VF_LAST  = VW'(V_FRONT - 1);

  dvp_state_t    r_state, w_state_nxt;
  logic [HW-1:0] r_hcnt, w_hcnt_nxt;
  logic [VW-1:0] r_vcnt, w_vcnt_nxt;
  logic [VW-1:0] w_phase_last;
  logic          w_href_nxt;

  always_ff @(posedge i_pclk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_hcnt  <= '0;
      r_vcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_vcnt  <= w_vcnt_nxt;
    end
  end

  always_comb begin
    w_phase_last = VS_LAST;
    case (r_state)
      ST_VBACK:  w_phase_last = VB_LAST;
      ST_ACTIVE: w_phase_last = VA_LAST;
      ST_VFRONT: w_phase_last = VF_LAST;
      default:   w_phase_last = VS_LAST;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    w_vcnt_nxt  = r_vcnt;
    if (r_state == ST_IDLE) begin
      w_hcnt_nxt = '0;
      w_vcnt_nxt = '0;
      if (i_enable) w_state_nxt = ST_VSYNC;
    end else if (r_hcnt != H_LAST) begin
      w_hcnt_nxt = r_hcnt + HW'(1);
    end else begin
      w_hcnt_nxt = '0;
      if (r_vcnt != w_phase_last) begin
        w_vcnt_nxt = r_vcnt + VW'(1);
      end else begin
        w_vcnt_nxt = '0;
        case (r_state)
          ST_VSYNC:  w_state_nxt = ST_VBACK;
          ST_VBACK:  w_state_nxt = ST_ACTIVE;
          ST_ACTIVE: w_state_nxt = ST_VFRONT;
          ST_VFRONT: w_state_nxt = i_enable ? ST_VSYNC : ST_IDLE;
          default:   w_state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  // Even hcnt within the href window is byte0 of a pixel, odd is byte1.
  assign w_href_nxt       = (w_state_nxt == ST_ACTIVE) && (w_hcnt_nxt < HREF_END);
  assign o_vsync_nxt      = (w_state_nxt == ST_VSYNC);
  assign o_href_nxt       = w_href_nxt;
  assign o_byte0_nxt      = w_href_nxt && !w_hcnt_nxt[0];
  assign o_byte1_nxt      = w_href_nxt && w_hcnt_nxt[0];
  assign o_first_pix_nxt  = w_href_nxt && (w_hcnt_nxt == '0) && (w_vcnt_nxt == '0);
  assign o_last_pix_nxt   = w_href_nxt && (w_hcnt_nxt == LAST_B0);
  assign o_frame_done_nxt = (w_state_nxt == ST_VFRONT) && (w_vcnt_nxt == VF_LAST) &&
                            (w_hcnt_nxt == H_LAST);
  assign o_vback          = (r_state == ST_VBACK);

endmodule

// File: rtl/ov5640_dvp_tx.sv
// AXI4-Stream RGB888 to OV5640-style DVP (VSYNC/HREF/D, RGB565 two bytes per pixel).
// Stream fetch, byte mux and SOF/EOL checking; frame timing lives in dvp_timing_gen.
module ov5640_dvp_tx
  import ov5640_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int H_BLANK     = DEF_H_BLANK,
  parameter int VSYNC_LINES = DEF_VSYNC_LINES,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int V_FRONT     = DEF_V_FRONT
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        enable,
  input  logic        clr_status,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  output logic        dvp_vsync,
  output logic        dvp_href,
  output logic [7:0]  dvp_d,
  output logic        frame_done,
  output logic        underflow,
  output logic        sync_err
);

  logic        w_vsync_nxt, w_href_nxt, w_byte0_nxt, w_byte1_nxt;
  logic        w_first_pix, w_last_pix, w_frame_done_nxt, w_vback;
  logic        w_fetch, w_discard, w_take, w_starve, w_sync_bad;
  logic [15:0] w_pix_bytes;
  logic        w_unused_hi;

  logic        r_vsync, r_href, r_frame_done, r_underflow, r_sync_err;
  logic [7:0]  r_d, r_byte1;

  dvp_timing_gen #(
    .H_ACTIVE    (H_ACTIVE),
    .V_ACTIVE    (V_ACTIVE),
    .H_BLANK     (H_BLANK),
    .VSYNC_LINES (VSYNC_LINES),
    .V_BACK      (V_BACK),
    .V_FRONT     (V_FRONT)
  ) u_timing (
    .i_pclk           (pclk),
    .i_reset          (reset),
    .i_enable         (enable),
    .o_vsync_nxt      (w_vsync_nxt),
    .o_href_nxt       (w_href_nxt),
    .o_byte0_nxt      (w_byte0_nxt),
    .o_byte1_nxt      (w_byte1_nxt),
    .o_first_pix_nxt  (w_first_pix),
    .o_last_pix_nxt   (w_last_pix),
    .o_frame_done_nxt (w_frame_done_nxt),
    .o_vback          (w_vback)
  );

  // During back porch, non-SOF beats are drained so a misaligned stream resyncs on tuser.
  assign w_fetch       = w_byte0_nxt;
  assign w_discard     = w_vback && !w_fetch && !s_axis_tuser;
  assign s_axis_tready = w_fetch || w_discard;
  assign w_take        = w_fetch && s_axis_tvalid;
  assign w_starve      = w_fetch && !s_axis_tvalid;
  assign w_pix_bytes   = rgb888_to_565_bytes(s_axis_tdata[23:0]);
  assign w_sync_bad    = w_take && ((s_axis_tuser != w_first_pix) || (s_axis_tlast != w_last_pix));
  assign w_unused_hi   = ^s_axis_tdata[31:24];

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_vsync      <= 1'b0;
      r_href       <= 1'b0;
      r_frame_done <= 1'b0;
      r_d          <= 8'h00;
      r_byte1      <= 8'h00;
      r_underflow  <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_vsync      <= w_vsync_nxt;
      r_href       <= w_href_nxt;
      r_frame_done <= w_frame_done_nxt;

      // A starved slot sends zeros for both bytes; the pixel is not made up later.
      if (w_fetch) begin
        r_d     <= w_take ? w_pix_bytes[15:8] : 8'h00;
        r_byte1 <= w_take ? w_pix_bytes[7:0]  : 8'h00;
      end else if (w_byte1_nxt) begin
        r_d <= r_byte1;
      end else begin
        r_d <= 8'h00;
      end

      if (w_starve)        r_underflow <= 1'b1;
      else if (clr_status) r_underflow <= 1'b0;

      if (w_sync_bad)      r_sync_err <= 1'b1;
      else if (clr_status) r_sync_err <= 1'b0;
    end
  end

  assign dvp_vsync  = r_vsync;
  assign dvp_href   = r_href;
  assign dvp_d      = r_d;
  assign frame_done = r_frame_done;
  assign underflow  = r_underflow;
  assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_ov5640_dvp_tx.sv
// Randomized bench for ov5640_dvp_tx against a frame-position reference model.
module tb_ov5640_dvp_tx;

  localparam int H     = 4;
  localparam int VA    = 2;
  localparam int HB    = 3;
  localparam int VS    = 1;
  localparam int VB    = 1;
  localparam int VF    = 1;
  localparam int LP    = 2 * H + HB;
  localparam int FRAME = (VS + VB + VA + VF) * LP;
  localparam int ACT0  = (VS + VB) * LP;

  logic        pclk = 1'b0;
  logic        reset, enable, clr_status;
  logic [31:0] tdata;
  logic        tvalid, tready, tuser, tlast;
  logic        vsync, href, fd, uf, se;
  logic [7:0]  d;

  always #5 pclk = ~pclk;

  ov5640_dvp_tx #(
    .H_ACTIVE(H), .V_ACTIVE(VA), .H_BLANK(HB),
    .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .pclk          (pclk),
    .reset         (reset),
    .enable        (enable),
    .clr_status    (clr_status),
    .s_axis_tdata  (tdata),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .s_axis_tuser  (tuser),
    .s_axis_tlast  (tlast),
    .dvp_vsync     (vsync),
    .dvp_href      (href),
    .dvp_d         (d),
    .frame_done    (fd),
    .underflow     (uf),
    .sync_err      (se)
  );

  typedef struct {
    logic [23:0] rgb;
    logic        user;
    logic        last;
  } beat_t;

  beat_t       src_q[$];
  logic [23:0] fixed_px [4] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF};
  logic [7:0]  exp_line [8] = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};

  int tests = 0;
  int fails = 0;

  // Model state: m_pos is the frame cycle currently shown on the outputs (-1 = idle).
  int         m_pos;
  logic [7:0] m_b1;
  logic       m_uf, m_se;
  int         stall_pos, stall_pct;
  logic [13:0] exp_v, obs_v;

  function automatic bit is_href(input int p);
    int ln, h;
    if (p < 0) return 0;
    ln = p / LP;
    h  = p % LP;
    return (ln >= VS + VB) && (ln < VS + VB + VA) && (h < 2 * H);
  endfunction

  function automatic bit is_b0(input int p);
    return is_href(p) && ((p % LP) % 2 == 0);
  endfunction

  task automatic model_reset();
    m_pos = -1;
    m_b1  = 8'h00;
    m_uf  = 1'b0;
    m_se  = 1'b0;
    stall_pos = -1;
    stall_pct = 0;
    src_q.delete();
  endtask

  task automatic push_frame(input int extra_last, input bit fixed);
    beat_t bt;
    for (int ln = 0; ln < VA; ln++) begin
      for (int k = 0; k < H; k++) begin
        bt.rgb  = (fixed && ln == 0) ? fixed_px[k] : 24'($urandom);
        bt.user = (ln == 0 && k == 0);
        bt.last = (k == H - 1) || (ln == 0 && k == extra_last);
        src_q.push_back(bt);
      end
    end
  endtask

  task automatic push_junk(input int n);
    beat_t bt;
    for (int i = 0; i < n; i++) begin
      bt.rgb  = 24'($urandom);
      bt.user = 1'b0;
      bt.last = 1'($urandom_range(1));
      src_q.push_back(bt);
    end
  endtask

  // One pclk cycle: called at a negedge, drives the source, predicts, returns at the next negedge.
  task automatic tick();
    int npos, ln, k, rr, gg, bb;
    bit fetch, stall, exp_rdy, obs_rdy, uf_set, se_set;
    logic [7:0] dn;
    npos  = (m_pos < 0 || m_pos == FRAME - 1) ? (enable ? 0 : -1) : m_pos + 1;
    fetch = is_b0(npos);
    stall = (npos == stall_pos) || (int'($urandom_range(99)) < stall_pct);
    if (src_q.size() > 0 && !stall) begin
      tvalid = 1'b1;
      tdata  = {8'($urandom), src_q[0].rgb};
      tuser  = src_q[0].user;
      tlast  = src_q[0].last;
    end else begin
      tvalid = 1'b0;
      tdata  = $urandom;
      tuser  = 1'b0;
      tlast  = 1'b0;
    end
    #1;
    obs_rdy = tready;
    exp_rdy = fetch || (m_pos >= 0 && m_pos / LP >= VS && m_pos / LP < VS + VB && !tuser);
    uf_set = 0;
    se_set = 0;
    dn = 8'h00;
    if (fetch) begin
      if (tvalid) begin
        rr = int'(tdata[23:16]);
        gg = int'(tdata[15:8]);
        bb = int'(tdata[7:0]);
        dn   = 8'((rr / 8) * 8 + gg / 32);
        m_b1 = 8'(((gg / 4) % 8) * 32 + bb / 8);
        k  = (npos % LP) / 2;
        ln = npos / LP;
        if (tuser != (k == 0 && ln == VS + VB)) se_set = 1;
        if (tlast != (k == H - 1)) se_set = 1;
      end else begin
        m_b1 = 8'h00;
        uf_set = 1;
      end
    end else if (is_href(npos)) begin
      dn = m_b1;
    end
    m_uf = uf_set ? 1'b1 : (clr_status ? 1'b0 : m_uf);
    m_se = se_set ? 1'b1 : (clr_status ? 1'b0 : m_se);
    exp_v = {exp_rdy, (npos >= 0 && npos / LP < VS), is_href(npos), dn,
             (npos == FRAME - 1), m_uf, m_se};
    @(posedge pclk);
    if (tvalid && tready) void'(src_q.pop_front());
    m_pos = npos;
    #1;
    obs_v = {obs_rdy, vsync, href, d, fd, uf, se};
    @(negedge pclk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge pclk);
    tests++;
    if ({vsync, href, d, fd, uf, se, tready} !== 14'h0)
      begin fails++; $display("FAIL reset_hold: got %h want 0", {vsync, href, d, fd, uf, se, tready}); end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL reset_idle[%0d]: got %h want %h", i, obs_v, exp_v); end
    end
  endtask

  task automatic test_first_line();
    logic [7:0] seen[$];
    push_frame(-1, 1);
    enable = 1'b1;
    for (int i = 0; i < FRAME + 5; i++) begin
      if (i == 10) enable = 1'b0;
      tick();
      tests++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL first_line[%0d]: got %h want %h", i, obs_v, exp_v); end
      if (href && m_pos / LP == VS + VB) seen.push_back(d);
    end
    tests++;
    if (seen.size() != 8) begin fails++; $display("FAIL first_line_href_len: got %0d want 8", seen.size()); end
    for (int i = 0; i < 8 && i < seen.size(); i++) begin
      tests++;
      if (seen[i] !== exp_line[i]) begin fails++; $display("FAIL first_line_byte[%0d]: got %h want %h", i, seen[i], exp_line[i]); end
    end
  endtask

  task automatic test_continuous();
    int vs_cnt = 0, fd_cnt = 0, last_fd = -1, gap_bad = 0, quiet_bad = 0;
    for (int f = 0; f < 3; f++) push_frame(-1, 0);
    enable = 1'b1;
    for (int i = 0; i < 3 * FRAME + 15; i++) begin
      if (i == 2 * FRAME + 20) enable = 1'b0;
      tick();
      tests++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL continuous[%0d]: got %h want %h", i, obs_v, exp_v); end
      if (i < 3 * FRAME) begin
        if (vsync) vs_cnt++;
        if (fd) begin
          if (last_fd >= 0 && i - last_fd != FRAME) gap_bad++;
          last_fd = i;
          fd_cnt++;
        end
      end else if (vsync || href) quiet_bad++;
    end
    tests++;
    if (vs_cnt != 3 * VS * LP) begin fails++; $display("FAIL vsync_width: got %0d want %0d", vs_cnt, 3 * VS * LP); end
    tests++;
    if (fd_cnt != 3 || gap_bad != 0 || last_fd != 3 * FRAME - 1)
      begin fails++; $display("FAIL frame_done_period: got cnt=%0d bad=%0d last=%0d want 3/0/%0d", fd_cnt, gap_bad, last_fd, 3 * FRAME - 1); end
    tests++;
    if (quiet_bad != 0) begin fails++; $display("FAIL stop_after_frame: got %0d active cycles want 0", quiet_bad); end
  endtask

  task automatic test_underflow();
    logic [7:0] d0 = 8'hAA, d1 = 8'hAA;
    logic uf_end;
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    push_frame(-1, 0);
    stall_pos = ACT0 + 4;
    enable = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      if (i == 5) enable = 1'b0;
      tick();
      tests++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL underflow[%0d]: got %h want %h", i, obs_v, exp_v); end
      if (m_pos == ACT0 + 4) d0 = d;
      if (m_pos == ACT0 + 5) d1 = d;
    end
    uf_end = uf;
    stall_pos = -1;
    tests++;
    if ({d0, d1, uf_end} !== {16'h0000, 1'b1}) begin fails++; $display("FAIL underflow_slot: got d=%h%h uf=%b want 0000 uf=1", d0, d1, uf_end); end
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    tests++;
    if (obs_v !== exp_v || uf !== 1'b0) begin fails++; $display("FAIL underflow_clear: got %h uf=%b want %h uf=0", obs_v, uf, exp_v); end
    src_q.delete();
  endtask

  task automatic test_sof_resync();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    push_junk(3);
    push_frame(-1, 0);
    enable = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      if (i == 5) enable = 1'b0;
      tick();
      tests++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL sof_resync[%0d]: got %h want %h", i, obs_v, exp_v); end
    end
    tests++;
    if (se !== 1'b0 || uf !== 1'b0 || src_q.size() != 0)
      begin fails++; $display("FAIL sof_resync_end: got se=%b uf=%b left=%0d want 0/0/0", se, uf, src_q.size()); end
  endtask

  task automatic test_tlast_err();
    int href_cnt = 0;
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    push_frame(1, 0);
    enable = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      if (i == 5) enable = 1'b0;
      tick();
      tests++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL tlast_err[%0d]: got %h want %h", i, obs_v, exp_v); end
      if (href) href_cnt++;
    end
    tests++;
    if (se !== 1'b1 || href_cnt != VA * 2 * H)
      begin fails++; $display("FAIL tlast_err_end: got se=%b href=%0d want 1/%0d", se, href_cnt, VA * 2 * H); end
  endtask

  task automatic test_reset_mid();
    push_frame(-1, 0);
    enable = 1'b1;
    for (int i = 0; i < ACT0 + 3; i++) begin
      tick();
      tests++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL reset_mid_run[%0d]: got %h want %h", i, obs_v, exp_v); end
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({vsync, href, d} !== 10'h0) begin fails++; $display("FAIL reset_mid_async: got %h want 0", {vsync, href, d}); end
    model_reset();
    @(negedge pclk);
    reset = 1'b0;
    tick();
    tests++;
    if (obs_v !== exp_v || vsync !== 1'b1) begin fails++; $display("FAIL reset_restart: got %h want %h", obs_v, exp_v); end
    enable = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      tests++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL reset_mid_tail[%0d]: got %h want %h", i, obs_v, exp_v); end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      if ($urandom_range(1) == 1) push_junk(int'($urandom_range(3, 1)));
      push_frame(-1, 0);
    end
    stall_pct = 8;
    enable = 1'b1;
    for (int i = 0; i < 4 * FRAME + 5; i++) begin
      clr_status = ($urandom_range(15) == 0);
      if (i == 4 * FRAME - 30) enable = 1'b0;
      tick();
      tests++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL random[%0d]: got %h want %h", i, obs_v, exp_v); end
    end
    clr_status = 1'b0;
    stall_pct = 0;
    src_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    clr_status = 1'b0;
    tvalid = 1'b0;
    tdata = 32'h0;
    tuser = 1'b0;
    tlast = 1'b0;
    model_reset();
    test_reset();
    test_first_line();
    test_continuous();
    test_underflow();
    test_sof_resync();
    test_tlast_err();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
